board_mem_arbiter: RTL and testbench



---
 rtl/board_mem_arbiter.sv | 104 ++++++++++
 tb/tb_board_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: round-robin req/gnt/release arbiter with hold watchdog for the shared 64x4 board RAM
//   clk, reset               : clock, synchronous active-high reset
//   i_req/i_rel              : per-requester level request / release pulse (0 control, 1 validator, 2 datapath, 3 view)
//   i_req_addr/we/wdata      : flattened per-requester access, requester i at slice i
//   i_force_en/i_force_sel   : priority override for the next arbitration
//   i_mem_rdata              : RAM read data, one cycle after address
//   o_gnt                    : one-hot grant
//   o_mem_addr/we/wdata      : RAM access of the current owner
//   o_rdata/o_rvalid         : read data returned to the owner, one-hot valid
//   o_owner/o_busy           : current or last owner, high while owning or draining
//   o_timeout_err            : sticky watchdog flag
module board_mem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            i_req,
    input  logic [3:0]            i_rel,
    input  logic [4*ADDR_W-1:0]   i_req_addr,
    input  logic [3:0]            i_req_we,
    input  logic [4*DATA_W-1:0]   i_req_wdata,
    input  logic                  i_force_en,
    input  logic [1:0]            i_force_sel,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic [3:0]            o_gnt,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [3:0]            o_rvalid,
    output logic [1:0]            o_owner,
    output logic                  o_busy,
    output logic                  o_timeout_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state, r_owner, r_rr_last;
    logic [7:0]        r_hold_cnt;
    logic              r_timeout_err;
    logic [3:0]        r_rvalid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              w_own, w_to, w_exit;
    logic [1:0]        w_win, w_idx;
    logic [ADDR_W-1:0] w_addr;

    assign w_own  = r_state == S_OWN;
    assign w_addr = i_req_addr[r_owner*ADDR_W +: ADDR_W];
    assign w_to   = r_hold_cnt == 8'(MAX_HOLD);
    assign w_exit = i_rel[r_owner] | ~i_req[r_owner] | w_to;

    // Scan from rr_last+1 upward; walking k downward lets the nearest requester win.
    always_comb begin
        w_win = r_rr_last;
        w_idx = r_rr_last;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_rr_last + 2'(k);
            if (i_req[w_idx]) w_win = w_idx;
        end
        if (i_force_en && i_req[i_force_sel]) w_win = i_force_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 2'd0;
            r_rr_last     <= 2'd3;
            r_hold_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
            r_rvalid      <= 4'd0;
            r_mem_addr    <= '0;
        end else begin
            r_rvalid <= o_gnt & ~i_req_we;
            if (w_own) r_mem_addr <= w_addr;
            case (r_state)
                S_IDLE: if (|i_req) begin
                    r_owner    <= w_win;
                    r_rr_last  <= w_win;
                    r_hold_cnt <= 8'd0;
                    r_state    <= S_OWN;
                end
                S_OWN: begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                    if (w_exit) r_state <= S_DRAIN;
                    if (w_to) r_timeout_err <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_gnt         = w_own ? 4'(1 << r_owner) : 4'd0;
    assign o_mem_addr    = w_own ? w_addr : r_mem_addr;
    assign o_mem_we      = w_own & i_req_we[r_owner];
    assign o_mem_wdata   = w_own ? i_req_wdata[r_owner*DATA_W +: DATA_W] : '0;
    assign o_rvalid      = r_rvalid;
    assign o_rdata       = |r_rvalid ? i_mem_rdata : '0;
    assign o_owner       = r_owner;
    assign o_busy        = r_state != S_IDLE;
    assign o_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: scoreboard bench for board_mem_arbiter with a behavioural board RAM
module tb_board_mem_arbiter;
    logic        clk = 0, reset = 1;
    logic [3:0]  req = 0, rel = 0, we = 0;
    logic        force_en = 0;
    logic [1:0]  force_sel = 0;
    logic [5:0]  a [4];
    logic [3:0]  wd [4];
    logic [3:0]  mem_rdata = 0;
    logic [3:0]  gnt, rvalid, rdata, mem_wdata;
    logic [5:0]  mem_addr;
    logic        mem_we, busy, timeout_err;
    logic [1:0]  owner;
    logic [3:0]  ram [64];
    logic [3:0]  qv [$];
    logic [3:0]  qd [$];
    logic [3:0]  ev, ed;
    int          n_checks = 0, n_errors = 0;

    board_mem_arbiter dut (
        .clk(clk), .reset(reset), .i_req(req), .i_rel(rel),
        .i_req_addr({a[3], a[2], a[1], a[0]}), .i_req_we(we),
        .i_req_wdata({wd[3], wd[2], wd[1], wd[0]}),
        .i_force_en(force_en), .i_force_sel(force_sel), .i_mem_rdata(mem_rdata),
        .o_gnt(gnt), .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_owner(owner), .o_busy(busy),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Read-return scoreboard: every read grant cycle expects rvalid/rdata one cycle later.
    always @(negedge clk) begin
        if (qv.size() > 0) begin
            ev = qv.pop_front();
            ed = qd.pop_front();
            check("sb_rvalid", 32'(rvalid), 32'(ev));
            if (ev != 0) check("sb_rdata", 32'(rdata), 32'(ed));
        end
        if (gnt == 0) check("sb_we_idle", 32'(mem_we), 0);
        ev = 0;
        ed = 0;
        for (int i = 0; i < 4; i++)
            if (gnt[i] && !we[i] && !reset) begin
                ev = 4'(1 << i);
                ed = ram[a[i]];
            end
        qv.push_back(ev);
        qd.push_back(ed);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic grant_release(input logic [3:0] r, input logic fe, input logic [1:0] fs, input logic [1:0] exp);
        req = r;
        force_en = fe;
        force_sel = fs;
        cyc();
        check("arb_gnt", 32'(gnt), 32'(1 << exp));
        check("arb_owner", 32'(owner), 32'(exp));
        req = 0;
        force_en = 0;
        cyc();
        check("arb_drain_gnt", 32'(gnt), 0);
        check("arb_drain_busy", 32'(busy), 1);
        cyc();
        check("arb_idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 64; i++) ram[i] = 4'(i * 7 + 3);
        ram[9] = 4'd6;
        ram[5] = 4'd11;
        for (int i = 0; i < 4; i++) begin
            a[i] = 6'(16 + i);
            wd[i] = 0;
        end
        #2;
        do_reset();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_we", 32'(mem_we), 0);

        a[2] = 6'd9;
        req = 4'b0100;
        cyc();
        check("single_gnt", 32'(gnt), 32'(4'b0100));
        check("single_addr", 32'(mem_addr), 9);
        check("single_owner", 32'(owner), 2);
        req = 0;
        cyc();
        check("single_rvalid", 32'(rvalid), 32'(4'b0100));
        check("single_rdata", 32'(rdata), 6);
        check("single_drain_gnt", 32'(gnt), 0);
        cyc();
        check("single_idle_busy", 32'(busy), 0);
        check("single_owner_kept", 32'(owner), 2);
        check("single_addr_held", 32'(mem_addr), 9);

        do_reset();
        a[1] = 6'd5;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            check("rr_owner", 32'(owner), 32'(k % 4));
            cyc();
            rel = 4'(1 << (k % 4));
            check("rr_gnt2", 32'(gnt), 32'(1 << (k % 4)));
            cyc();
            rel = 0;
            if (k == 4) req = 0;
            check("rr_drain_gnt", 32'(gnt), 0);
            check("rr_drain_we", 32'(mem_we), 0);
            check("rr_drain_busy", 32'(busy), 1);
            check("rr_drain_rvalid", 32'(rvalid), 32'(1 << (k % 4)));
            check("rr_drain_rdata", 32'(rdata), 32'(ram[a[k % 4]]));
            cyc();
            check("rr_gap_gnt", 32'(gnt), 0);
            check("rr_gap_busy", 32'(busy), 0);
        end

        grant_release(4'b1110, 1, 2'd3, 2'd3);
        grant_release(4'b0001, 0, 2'd0, 2'd0);
        grant_release(4'b0110, 1, 2'd3, 2'd1);
        check("no_terr", 32'(timeout_err), 0);

        req = 4'b0001;
        cyc();
        cnt = 0;
        for (int i = 0; i < 300 && gnt == 4'b0001; i++) begin
            cnt++;
            if (cnt == 256) check("wd_terr_pre", 32'(timeout_err), 0);
            cyc();
        end
        check("wd_hold_cycles", cnt, 256);
        check("wd_terr", 32'(timeout_err), 1);
        check("wd_drain_busy", 32'(busy), 1);
        req = 0;
        cyc();
        cyc();
        check("wd_terr_sticky", 32'(timeout_err), 1);

        a[2] = 6'd20;
        wd[2] = 4'hA;
        we = 4'b0100;
        req = 4'b0100;
        cyc();
        check("wr_gnt", 32'(gnt), 32'(4'b0100));
        check("wr_we", 32'(mem_we), 1);
        check("wr_addr", 32'(mem_addr), 20);
        check("wr_data", 32'(mem_wdata), 32'(4'hA));
        reset = 1;
        cyc();
        check("mrst_gnt", 32'(gnt), 0);
        check("mrst_we", 32'(mem_we), 0);
        check("mrst_terr", 32'(timeout_err), 0);
        check("mrst_busy", 32'(busy), 0);
        check("wr_ram", 32'(ram[20]), 32'(4'hA));
        reset = 0;
        we = 0;
        a[0] = 6'd20;
        req = 4'b0101;
        cyc();
        check("mrst_first", 32'(gnt), 32'(4'b0001));
        req = 0;
        cyc();
        check("mrst_rdata", 32'(rdata), 32'(4'hA));
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
